fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter NUM_SRC, default 2, SHALL set the number of source operands per instruction (legal values 2..3).
REQ-003 Parameter MC_LAT, default 4, SHALL set the multi-cycle unit latency in cycles from issue to result (legal range 2..31; elaboration error otherwise).
REQ-004 Ports SHALL be:
 clk  in  1  clock
 rst_n  in  1  async active-low reset
 rs_id  in  NUM_SRC*5  source registers of the instruction in ID
 rd_id  in  5  destination register of the instruction in ID
 mc_req_id  in  1  instruction in ID is a multi-cycle op (mul/div)
 rs_ex  in  NUM_SRC*5  source registers of the instruction in EX
 rd_ex  in  5  destination register of the instruction in EX
 reg_write_ex  in  1  EX instruction writes rd
 mem_read_ex  in  1  EX instruction is a load
 rd_mem  in  5  destination register in MEM
 reg_write_mem  in  1  MEM instruction writes rd
 rd_wb  in  5  destination register in WB
 reg_write_wb  in  1  WB instruction writes rd
 flush  in  1  squash the instruction in ID (branch/jump redirect)
 fwd_sel  out  NUM_SRC*2  per-source operand mux select for EX
 stall  out  1  hold PC and IF/ID
 bubble  out  1  insert NOP into ID/EX
 mc_busy  out  1  multi-cycle op in flight
 mc_done  out  1  one-cycle pulse: multi-cycle result written this cycle
 mc_rd  out  5  destination of in-flight multi-cycle op

Function
REQ-005 For each source i, fwd_sel[i] SHALL be combinational: 2'b10 if reg_write_mem, rd_mem!=0 and rd_mem==rs_ex[i]; else 2'b01 if reg_write_wb, rd_wb!=0 and rd_wb==rs_ex[i]; else 2'b00 (MEM priority over WB).
REQ-006 A load-use hazard (mem_read_ex, reg_write_ex, rd_ex!=0, rd_ex equals any nonzero rs_id[i]) SHALL assert stall and bubble in the same cycle.
REQ-007 The scoreboard FSM SHALL have states IDLE, BUSY and DONE.
REQ-008 An issue SHALL occur when mc_req_id=1, stall=0 and flush=0 in IDLE or DONE; it SHALL latch rd_id into mc_rd, load the counter with MC_LAT-2 and enter BUSY next cycle.
REQ-009 In BUSY the counter SHALL decrement each cycle; the cycle it reads 0 the FSM SHALL go to DONE.
REQ-010 DONE SHALL last exactly one cycle with mc_done=1, then return to IDLE unless a new issue occurs (then BUSY).
REQ-011 mc_busy SHALL equal 1 in BUSY and 0 otherwise.
REQ-012 In BUSY, stall and bubble SHALL assert if any nonzero rs_id[i] equals mc_rd, or rd_id equals mc_rd (WAW), or mc_req_id=1 (structural).
REQ-013 In DONE, no RAW stall SHALL be raised against mc_rd; the register file is write-first.
REQ-014 flush SHALL force bubble=1 and stall=0, SHALL block issue that cycle, and SHALL NOT cancel an op already in BUSY or DONE.
REQ-015 Register x0 SHALL never cause forwarding, stall or scoreboard tracking; issue with rd_id=0 SHALL still run the FSM and occupy the unit.

Reset
REQ-016 On rst_n low, asynchronously: FSM to IDLE; counter, mc_rd, mc_busy and mc_done to 0.
REQ-017 With rst_n low, stall and bubble SHALL be 0; an in-flight op SHALL be discarded with no mc_done.

Configuration
REQ-018 With HAZ_STATS_EN defined, output stall_cycles (32 bits) SHALL count cycles with stall=1, saturate at 32'hFFFF_FFFF and reset to 0; without HAZ_STATS_EN, the port and counter SHALL be absent.

Structure
REQ-019 Package hazard_pkg SHALL hold enum fwd_sel_e (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), enum mc_state_e (IDLE, BUSY, DONE) and REG_ADDR_W=5.
REQ-020 The FSM, counter and mc_rd register SHALL live in sub-module mc_scoreboard; forwarding and stall logic SHALL stay in the top module.

Verification
REQ-021 rs_ex[0]=5, rd_mem=5 and rd_wb=5, both writes set -> fwd_sel[0]=2'b10; clearing reg_write_mem -> 2'b01.
REQ-022 mem_read_ex=1, rd_ex=7, rs_id[1]=7 -> stall=bubble=1 that cycle; with rd_ex=0 -> no stall.
REQ-023 MC_LAT=4, issue with rd_id=9 at cycle t -> mc_busy cycles t+1..t+2, mc_done=1 at t+3, rs_id=9 stalls during t+1..t+2 and not at t+3.
REQ-024 Second mc_req_id during BUSY -> stall until DONE, then issue in the DONE cycle, giving back-to-back BUSY with no IDLE cycle.
REQ-025 flush with mc_req_id=1 in IDLE -> no issue and bubble=1; rst_n low mid-BUSY -> IDLE immediately and no mc_done.
REQ-026 With HAZ_STATS_EN, 3 load-use stalls -> stall_cycles=3; preload near max -> holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and widths for the forwarding / hazard unit and its multi-cycle scoreboard.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int MC_CNT_W   = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mc_state_e;

endpackage

// File: rtl/mc_scoreboard.sv
// Tracks one in-flight multi-cycle op: IDLE -> BUSY (countdown) -> DONE (one cycle).
module mc_scoreboard
    import hazard_pkg::*;
#(
    parameter int MC_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_req_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic                  mc_busy_o,
    output logic                  mc_done_o,
    output logic [REG_ADDR_W-1:0] mc_rd_o
);

    localparam logic [MC_CNT_W-1:0] CNT_LOAD = MC_CNT_W'(MC_LAT - 2);

    mc_state_e             state_q, state_d;
    logic [MC_CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        issue   = issue_req_i && (state_q != BUSY);
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (issue) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    rd_d    = rd_i;
                end
            end
            BUSY: begin
                // Leave BUSY on the cycle the decrement lands on zero (a load of 0 also exits).
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (cnt_d == '0) state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mc_busy_o = (state_q == BUSY);
    assign mc_done_o = (state_q == DONE);
    assign mc_rd_o   = rd_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding, load-use and multi-cycle hazard detection.
// Optional HAZ_STATS_EN adds a saturating stall_cycles counter output.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int MC_LAT  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0]         rd_id,
    input  logic                          mc_req_id,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_ex,
    input  logic [REG_ADDR_W-1:0]         rd_ex,
    input  logic                          reg_write_ex,
    input  logic                          mem_read_ex,
    input  logic [REG_ADDR_W-1:0]         rd_mem,
    input  logic                          reg_write_mem,
    input  logic [REG_ADDR_W-1:0]         rd_wb,
    input  logic                          reg_write_wb,
    input  logic                          flush,
    output logic [NUM_SRC*2-1:0]          fwd_sel,
    output logic                          stall,
    output logic                          bubble,
    output logic                          mc_busy,
    output logic                          mc_done,
    output logic [REG_ADDR_W-1:0]         mc_rd
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]                   stall_cycles
`endif
);

    if (NUM_SRC < 2 || NUM_SRC > 3) begin : g_bad_num_src
        $error("fwd_hazard_unit: NUM_SRC must be 2..3");
    end
    if (MC_LAT < 2 || MC_LAT > 31) begin : g_bad_mc_lat
        $error("fwd_hazard_unit: MC_LAT must be 2..31");
    end

    logic lu_match, mc_raw, load_use, mc_haz, hazard;

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reg_write_mem && rd_mem != '0 && rd_mem == rs_ex[i*REG_ADDR_W +: REG_ADDR_W])
                fwd_sel[2*i +: 2] = FWD_MEM;
            else if (reg_write_wb && rd_wb != '0 && rd_wb == rs_ex[i*REG_ADDR_W +: REG_ADDR_W])
                fwd_sel[2*i +: 2] = FWD_WB;
            else
                fwd_sel[2*i +: 2] = FWD_RF;
        end
    end

    always_comb begin
        lu_match = 1'b0;
        mc_raw   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rs_id[i*REG_ADDR_W +: REG_ADDR_W] != '0) begin
                if (rs_id[i*REG_ADDR_W +: REG_ADDR_W] == rd_ex) lu_match = 1'b1;
                if (rs_id[i*REG_ADDR_W +: REG_ADDR_W] == mc_rd) mc_raw   = 1'b1;
            end
        end
    end

    assign load_use = mem_read_ex && reg_write_ex && (rd_ex != '0) && lu_match;
    // DONE raises nothing: the result lands in the write-first register file that cycle.
    assign mc_haz   = mc_busy && (mc_raw || (rd_id != '0 && rd_id == mc_rd) || mc_req_id);
    assign hazard   = load_use || mc_haz;

    // Outputs are gated by rst_n so the pipeline sees no stall while reset is asserted.
    assign stall  = rst_n && !flush && hazard;
    assign bubble = rst_n && (flush || hazard);

    mc_scoreboard #(
        .MC_LAT (MC_LAT)
    ) u_mc_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_req_i (mc_req_id && !stall && !flush),
        .rd_i        (rd_id),
        .mc_busy_o   (mc_busy),
        .mc_done_o   (mc_done),
        .mc_rd_o     (mc_rd)
    );

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed bench for fwd_hazard_unit against a cycle-indexed reference model.
module tb_fwd_hazard_unit;

    localparam int NS  = 2;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS*5-1:0] rs_id, rs_ex;
    logic [4:0]    rd_id, rd_ex, rd_mem, rd_wb;
    logic          mc_req_id, reg_write_ex, mem_read_ex, reg_write_mem, reg_write_wb, flush;
    logic [NS*2-1:0] fwd_sel;
    logic          stall, bubble, mc_busy, mc_done;
    logic [4:0]    mc_rd;
`ifdef HAZ_STATS_EN
    logic [31:0]   stall_cycles;
`endif

    fwd_hazard_unit #(.NUM_SRC(NS), .MC_LAT(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs_id         (rs_id),
        .rd_id         (rd_id),
        .mc_req_id     (mc_req_id),
        .rs_ex         (rs_ex),
        .rd_ex         (rd_ex),
        .reg_write_ex  (reg_write_ex),
        .mem_read_ex   (mem_read_ex),
        .rd_mem        (rd_mem),
        .reg_write_mem (reg_write_mem),
        .rd_wb         (rd_wb),
        .reg_write_wb  (reg_write_wb),
        .flush         (flush),
        .fwd_sel       (fwd_sel),
        .stall         (stall),
        .bubble        (bubble),
        .mc_busy       (mc_busy),
        .mc_done       (mc_done),
        .mc_rd         (mc_rd)
`ifdef HAZ_STATS_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the in-flight op is described by the cycle numbers it is busy / done in.
    int         cyc     = 0;
    int         busy_lo = 0;
    int         busy_hi = -1;
    int         done_at = -1;
    logic [4:0] m_rd    = '0;

    function automatic logic [4:0] src(input logic [NS*5-1:0] v, input int i);
        return v[i*5 +: 5];
    endfunction

    task automatic model_reset();
        busy_lo = 0;
        busy_hi = -1;
        done_at = -1;
        m_rd    = '0;
    endtask

    task automatic drive_idle();
        rs_id = '0; rs_ex = '0; rd_id = '0; rd_ex = '0; rd_mem = '0; rd_wb = '0;
        mc_req_id = 0; reg_write_ex = 0; mem_read_ex = 0;
        reg_write_mem = 0; reg_write_wb = 0; flush = 0;
    endtask

    // Check all outputs for the current (settled) cycle, update the model, advance one clock.
    task automatic step();
        logic [NS*2-1:0] e_fwd;
        logic lu, mh, raw, b, e_stall, e_bubble;
        e_fwd = '0;
        for (int i = 0; i < NS; i++) begin
            if (reg_write_mem && rd_mem != 0 && rd_mem == src(rs_ex, i))    e_fwd[2*i +: 2] = 2'b10;
            else if (reg_write_wb && rd_wb != 0 && rd_wb == src(rs_ex, i)) e_fwd[2*i +: 2] = 2'b01;
        end
        lu  = 0;
        raw = 0;
        for (int i = 0; i < NS; i++) begin
            if (src(rs_id, i) != 0 && src(rs_id, i) == rd_ex) lu = 1;
            if (src(rs_id, i) != 0 && src(rs_id, i) == m_rd)  raw = 1;
        end
        lu = lu && mem_read_ex && reg_write_ex && rd_ex != 0;
        b  = (cyc >= busy_lo && cyc <= busy_hi);
        mh = b && (raw || (rd_id != 0 && rd_id == m_rd) || mc_req_id);
        e_stall  = !flush && (lu || mh);
        e_bubble = flush || lu || mh;
        chk("fwd_sel", 32'(fwd_sel), 32'(e_fwd));
        chk("stall",   32'(stall),   32'(e_stall));
        chk("bubble",  32'(bubble),  32'(e_bubble));
        chk("mc_busy", 32'(mc_busy), 32'(b));
        chk("mc_done", 32'(mc_done), 32'(cyc == done_at));
        chk("mc_rd",   32'(mc_rd),   32'(m_rd));
        if (mc_req_id && !e_stall && !flush && !b) begin
            busy_lo = cyc + 1;
            busy_hi = cyc + ((LAT - 2 > 1) ? LAT - 2 : 1);
            done_at = busy_hi + 1;
            m_rd    = rd_id;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        drive_idle();
        rst_n = 0;
        // A load-use pattern held during reset must not stall.
        mem_read_ex = 1; reg_write_ex = 1; rd_ex = 5'd7; rs_id[4:0] = 5'd7;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_stall",   32'(stall),   0);
        chk("rst_bubble",  32'(bubble),  0);
        chk("rst_mc_busy", 32'(mc_busy), 0);
        chk("rst_mc_done", 32'(mc_done), 0);
        chk("rst_mc_rd",   32'(mc_rd),   0);
        drive_idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

`ifdef HAZ_STATS_EN
        for (int k = 0; k < 3; k++) begin
            mem_read_ex = 1; reg_write_ex = 1; rd_ex = 5'd6; rs_id[4:0] = 5'd6;
            #3; step();
        end
        drive_idle();
        #3;
        chk("stats_three", stall_cycles, 32'd3);
        step();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        for (int k = 0; k < 3; k++) begin
            mem_read_ex = 1; reg_write_ex = 1; rd_ex = 5'd6; rs_id[4:0] = 5'd6;
            #2; step();
        end
        drive_idle();
        #3;
        chk("stats_sat", stall_cycles, 32'hFFFF_FFFF);
        step();
`endif

        // Forwarding priority: MEM over WB, then WB alone.
        rs_ex[4:0] = 5'd5; rd_mem = 5'd5; rd_wb = 5'd5; reg_write_mem = 1; reg_write_wb = 1;
        #3; chk("fwd_mem_prio", 32'(fwd_sel[1:0]), 32'h2); step();
        reg_write_mem = 0;
        #3; chk("fwd_wb", 32'(fwd_sel[1:0]), 32'h1); step();
        drive_idle();

        // Load-use on source 1, then rd_ex = x0.
        mem_read_ex = 1; reg_write_ex = 1; rd_ex = 5'd7; rs_id[9:5] = 5'd7;
        #3; chk("lu_stall", 32'(stall), 1); chk("lu_bubble", 32'(bubble), 1); step();
        rd_ex = 5'd0; rs_id[9:5] = 5'd0;
        #3; chk("lu_x0_stall", 32'(stall), 0); step();
        drive_idle();

        // Issue rd=9, dependent source waits through BUSY, released in DONE.
        mc_req_id = 1; rd_id = 5'd9;
        #3; chk("iss_stall", 32'(stall), 0); step();
        mc_req_id = 0; rd_id = 5'd0; rs_id[4:0] = 5'd9;
        #3; chk("t1_busy", 32'(mc_busy), 1); chk("t1_stall", 32'(stall), 1); step();
        #3; chk("t2_busy", 32'(mc_busy), 1); chk("t2_stall", 32'(stall), 1); step();
        #3; chk("t3_busy", 32'(mc_busy), 0); chk("t3_done", 32'(mc_done), 1);
        chk("t3_stall", 32'(stall), 0); step();
        #3; chk("t4_done", 32'(mc_done), 0); step();
        drive_idle();

        // Second request during BUSY waits, then issues in the DONE cycle.
        mc_req_id = 1; rd_id = 5'd3;
        #3; step();
        rd_id = 5'd4;
        #3; chk("b2b_stall1", 32'(stall), 1); step();
        #3; chk("b2b_stall2", 32'(stall), 1); step();
        #3; chk("b2b_done", 32'(mc_done), 1); chk("b2b_iss_stall", 32'(stall), 0); step();
        mc_req_id = 0; rd_id = 5'd0;
        #3; chk("b2b_busy", 32'(mc_busy), 1); chk("b2b_rd", 32'(mc_rd), 32'd4); step();
        #3; step();
        #3; chk("b2b_done2", 32'(mc_done), 1); step();
        drive_idle();
        #3; step();

        // Flush blocks issue in IDLE.
        flush = 1; mc_req_id = 1; rd_id = 5'd12;
        #3; chk("fl_bubble", 32'(bubble), 1); chk("fl_stall", 32'(stall), 0); step();
        drive_idle();
        #3; chk("fl_no_issue", 32'(mc_busy), 0); step();

        // Reset mid-BUSY discards the op with no done pulse.
        mc_req_id = 1; rd_id = 5'd11;
        #3; step();
        drive_idle();
        rs_id[4:0] = 5'd11;
        #3;
        rst_n = 0;
        #1;
        chk("rmid_busy",   32'(mc_busy), 0);
        chk("rmid_stall",  32'(stall),   0);
        chk("rmid_bubble", 32'(bubble),  0);
        chk("rmid_rd",     32'(mc_rd),   0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 4; k++) begin
            #3; chk("rmid_no_done", 32'(mc_done), 0); step();
        end

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            rs_id         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rs_ex         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rd_id         = 5'($urandom_range(0, 7));
            rd_ex         = 5'($urandom_range(0, 7));
            rd_mem        = 5'($urandom_range(0, 7));
            rd_wb         = 5'($urandom_range(0, 7));
            reg_write_ex  = 1'($urandom_range(0, 1));
            mem_read_ex   = 1'($urandom_range(0, 1));
            reg_write_mem = 1'($urandom_range(0, 1));
            reg_write_wb  = 1'($urandom_range(0, 1));
            mc_req_id     = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            #3; step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
